comar_rand_gen: RTL and testbench
=================================

COMAR_RAND_GEN -- requirements
Module: comar_rand_gen

Interface
REQ-001 Parameter NUM_GADGETS, default 1, is the number of 6-bit fresh-mask lanes, one per downstream two-share COMAR gadget; legal range 1..16.
REQ-002 Parameter WARMUP, default 16, is the number of LFSR advance cycles after seed load before output is valid; legal range 1..255.
REQ-003 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, is the reset, asynchronous and active-low.
REQ-005 Port seed_valid, input, 1, SHALL mean a seed is offered this cycle.
REQ-006 Port seed, input, 32, is the seed value.
REQ-007 Port seed_ready, output, 1, SHALL mean a seed is accepted this cycle if seed_valid is high.
REQ-008 Port r_valid, output, 1, SHALL mean the r word is valid.
REQ-009 Port r_ready, input, 1, SHALL mean the consumer takes r this cycle.
REQ-010 Port r, output, 6*NUM_GADGETS, carries the mask word; lane k is r[6k+5:6k] and maps to a gadget's r[5:0].
REQ-011 Port busy, output, 1, SHALL be high in LOAD and WARMUP.

Function
REQ-012 Lane k SHALL hold a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 0x80200003), shifting right with feedback from bit 0.
REQ-013 One "advance" SHALL be 6 consecutive Galois steps, unrolled combinationally.
REQ-014 The FSM SHALL have four states: IDLE (unseeded), LOAD, WARMUP and RUN.
REQ-015 seed_ready SHALL be high in IDLE and RUN, and low in LOAD and WARMUP.
REQ-016 A seed transfer (seed_valid & seed_ready) SHALL move the FSM to LOAD and register the seed.
REQ-017 In LOAD, lane k SHALL load seed ^ (k*0x9E3779B9 mod 2^32).
  - A derived lane seed of zero SHALL be replaced by 0x00000001.
  - LOAD SHALL last one cycle, then the FSM moves to WARMUP.
REQ-018 In WARMUP, every lane SHALL advance once per cycle for exactly WARMUP cycles, counted by an 8-bit counter; the FSM then moves to RUN.
REQ-019 In RUN, the output register SHALL load when r_valid is low or r_ready is high.
  - Each lane's r bits take that lane's current LFSR[5:0], and r_valid is set to 1.
  - All lanes advance in the same cycle.
REQ-020 In RUN, while r_valid is high and r_ready is low, r and every LFSR SHALL hold; no mask word is skipped or repeated.
REQ-021 A mask word SHALL be delivered at most once; consecutive accepted words SHALL come from consecutive advances.
REQ-022 First r_valid SHALL rise WARMUP+2 cycles after the seed transfer edge, with r_ready held high.
REQ-023 Sustained throughput in RUN SHALL be one word per cycle with r_ready held high.
REQ-024 Reseed in RUN: a seed transfer SHALL clear r_valid on the next edge regardless of r_ready.
  - The pending word is discarded and the FSM moves to LOAD.
  - A simultaneous r_ready in that cycle still completes that cycle's transfer.
REQ-025 In IDLE, LOAD and WARMUP, r_valid SHALL be 0 and r SHALL hold its previous value.

Reset
REQ-026 rst_n low SHALL asynchronously force, at any time including mid-WARMUP or mid-RUN:
  - FSM to IDLE, r_valid 0, r all-zero, busy 0, every LFSR to 0x00000001, warm-up counter 0;
  - seed_ready to 1 once in IDLE.
REQ-027 After rst_n deassertion, no output SHALL be valid until a new seed is loaded and warm-up completes.

Configuration
REQ-028 Macro COMAR_RAND_WORD_CNT_EN defined SHALL add output port word_cnt, 16 bits.
  - word_cnt increments on each r_valid & r_ready and saturates at 0xFFFF.
  - It clears on reset and on seed transfer.
REQ-029 Without COMAR_RAND_WORD_CNT_EN, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Reset, then seed 0x00000000 with NUM_GADGETS=1, WARMUP=16 -> lane 0 loads 0x00000001, busy high 17 cycles, r_valid rises at cycle 18, r equals the golden-model LFSR[5:0] after 16 advances.
REQ-031 NUM_GADGETS=4, seed 0x12345678, r_ready=1 for 100 cycles -> 100 words, each lane matching its golden model, no repeats or skips.
REQ-032 RUN with r_ready toggling 1,0,0,1 -> r stable during the low cycles, next accepted word equals the next advance.
REQ-033 Reseed 0xCAFEF00D in RUN with r_ready=0 -> r_valid 0 next cycle, seed_ready 0 through warm-up, new stream matches golden model for the new seed.
REQ-034 rst_n pulsed low mid-WARMUP (cycle 5) -> immediate IDLE, r_valid 0, seed_ready 1; a later seed gives the full WARMUP delay.
REQ-035 COMAR_RAND_WORD_CNT_EN defined, 70000 accepted words -> word_cnt saturates at 0xFFFF; a reseed clears it to 0.

Source files
------------

// File: rtl/comar_rand_gen.sv
// comar_rand_gen: fresh-mask generator for two-share COMAR gadgets.
// Each lane owns a 32-bit Galois LFSR (mask 0x80200003, right shift).
// One advance is six unrolled steps, so each lane yields 6 fresh bits per advance.
// After a seed is loaded, the LFSRs are advanced WARMUP times before the first word is offered.
// Optional feature: define COMAR_RAND_WORD_CNT_EN to add a saturating 16-bit word_cnt output.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both high.
// - seed: the producer holds seed_valid/seed until seed_ready is seen.
// - r: once r_valid rises, r is held stable until r_ready is seen. The only
//   exception is a reseed, which withdraws the pending word.
`timescale 1ns/1ps

module comar_rand_gen #(
    parameter int NUM_GADGETS = 1,
    parameter int WARMUP      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       seed_valid,
    input  logic [31:0]                seed,
    output logic                       seed_ready,
    output logic                       r_valid,
    input  logic                       r_ready,
    output logic [6*NUM_GADGETS-1:0]   r,
    output logic                       busy
`ifdef COMAR_RAND_WORD_CNT_EN
    ,
    output logic [15:0]                word_cnt
`endif
);

    localparam logic [31:0] POLY_MASK   = 32'h80200003;
    localparam logic [31:0] LANE_STRIDE = 32'h9E3779B9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WARM = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [31:0]                seed_q;
    logic [7:0]                 warm_cnt;
    logic                       warm_done;
    logic                       seed_xfer;
    logic                       out_load;
    logic                       lane_adv;
    logic [6*NUM_GADGETS-1:0]   lane_bits;

    // Six Galois steps, unrolled in combinational logic.
    function automatic logic [31:0] adv6(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < 6; i++) begin
            v = v[0] ? ((v >> 1) ^ POLY_MASK) : (v >> 1);
        end
        return v;
    endfunction

    assign seed_xfer = seed_valid & seed_ready;
    assign warm_done = (warm_cnt == 8'(WARMUP - 1));
    // A reseed in RUN takes priority: the pending word is dropped, not replaced.
    assign out_load  = (state == ST_RUN) && !seed_xfer && (!r_valid || r_ready);
    assign lane_adv  = (state == ST_WARM) || out_load;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode plus the seed_ready/busy outputs that depend only on state.
    always_comb begin
        state_nxt  = state;
        seed_ready = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                seed_ready = 1'b1;
                if (seed_valid) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                busy      = 1'b1;
                state_nxt = ST_WARM;
            end
            ST_WARM: begin
                busy = 1'b1;
                if (warm_done) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                seed_ready = 1'b1;
                if (seed_valid) state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture the accepted seed. Lanes derive their own seed from it during LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         seed_q <= 32'd0;
        else if (seed_xfer) seed_q <= seed;
    end

    // Warm-up advance counter. It is cleared in LOAD and wraps to 0 on the last WARMUP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt <= 8'd0;
        end else if (state == ST_LOAD) begin
            warm_cnt <= 8'd0;
        end else if (state == ST_WARM) begin
            warm_cnt <= warm_done ? 8'd0 : warm_cnt + 8'd1;
        end
    end

    for (genvar k = 0; k < NUM_GADGETS; k++) begin : g_lane
        localparam logic [31:0] LANE_OFS = 32'(k) * LANE_STRIDE;
        logic [31:0] lfsr_q;
        logic [31:0] lane_seed;

        // An all-zero state would lock the LFSR, so it is replaced by 1.
        assign lane_seed = ((seed_q ^ LANE_OFS) == 32'd0) ? 32'd1 : (seed_q ^ LANE_OFS);
        assign lane_bits[6*k +: 6] = lfsr_q[5:0];

        // Per-lane LFSR: it seeds in LOAD and advances during warm-up and on every word load.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lfsr_q <= 32'd1;
            end else if (state == ST_LOAD) begin
                lfsr_q <= lane_seed;
            end else if (lane_adv) begin
                lfsr_q <= adv6(lfsr_q);
            end
        end
    end

    // Output word register. It captures the lanes' low six bits before they advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r       <= '0;
            r_valid <= 1'b0;
        end else if (seed_xfer) begin
            r_valid <= 1'b0;
        end else if (out_load) begin
            r       <= lane_bits;
            r_valid <= 1'b1;
        end
    end

`ifdef COMAR_RAND_WORD_CNT_EN
    // Count delivered words since the last seed, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= 16'd0;
        end else if (seed_xfer) begin
            word_cnt <= 16'd0;
        end else if (r_valid && r_ready && (word_cnt != 16'hFFFF)) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_comar_rand_gen.sv
// Directed-plus-random bench for comar_rand_gen (NUM_GADGETS=4, WARMUP=16).
// A golden model produces the expected mask words: each lane is stepped WARMUP*6 times
// after seeding, and each delivered word is the lanes' low six bits before the next advance.
`timescale 1ns/1ps

module tb_comar_rand_gen;

    localparam int          NG   = 4;
    localparam int          WU   = 16;
    localparam int          W    = 6 * NG;
    localparam logic [31:0] MASK = 32'h80200003;
    localparam logic [31:0] GOLD = 32'h9E3779B9;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          seed_valid = 1'b0;
    logic [31:0]   seed = 32'd0;
    logic          seed_ready;
    logic          r_valid;
    logic          r_ready = 1'b0;
    logic [W-1:0]  r;
    logic          busy;
`ifdef COMAR_RAND_WORD_CNT_EN
    logic [15:0]   word_cnt;
`endif

    always #5 clk = ~clk;

    comar_rand_gen #(.NUM_GADGETS(NG), .WARMUP(WU)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_valid (seed_valid),
        .seed       (seed),
        .seed_ready (seed_ready),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r          (r),
        .busy       (busy)
`ifdef COMAR_RAND_WORD_CNT_EN
        ,
        .word_cnt   (word_cnt)
`endif
    );

    // ---------------- scoreboard / model ----------------
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0]  mdl[NG];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gstep(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ MASK) : (s >> 1);
    endfunction

    task automatic model_seed(input logic [31:0] s);
        logic [31:0] v;
        for (int k = 0; k < NG; k++) begin
            v = s ^ (32'(k) * GOLD);
            if (v == 32'd0) v = 32'd1;
            for (int i = 0; i < WU * 6; i++) v = gstep(v);
            mdl[k] = v;
        end
        exp_q.delete();
    endtask

    task automatic model_push();
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < NG; k++) begin
            w[6*k +: 6] = mdl[k][5:0];
            for (int i = 0; i < 6; i++) mdl[k] = gstep(mdl[k]);
        end
        exp_q.push_back(w);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a seed, waits (bounded) for acceptance, and leaves the sample point just after the transfer edge.
    task automatic send_seed(input logic [31:0] s);
        int n;
        n = 0;
        while (!seed_ready && n < 100) begin
            tick();
            n++;
        end
        check("seed_ready_wait", seed_ready, 1'b1);
        seed_valid = 1'b1;
        seed = s;
        tick();
        seed_valid = 1'b0;
        seed = $urandom;
        model_seed(s);
    endtask

    // Counts edges from the seed transfer until r_valid rises (bounded); seed_ready must stay low through warm-up.
    task automatic wait_valid(output int n);
        n = 0;
        while (!r_valid && n < 200) begin
            tick();
            n++;
            if (n <= WU) check("seed_ready_warm", seed_ready, 1'b0);
        end
    endtask

    // mode 0: ready high, 1: random ready, 2: 1,0,0,1 pattern, 3: ready high with no word checks.
    task automatic run_words(input int cycles, input int mode, output int acc);
        acc = 0;
        for (int i = 0; i < cycles; i++) begin
            case (mode)
                1:       r_ready = 1'($urandom_range(0, 1));
                2:       r_ready = ((i % 4) == 0) || ((i % 4) == 3);
                default: r_ready = 1'b1;
            endcase
            if (r_valid) begin
                if (mode != 3) begin
                    if (exp_q.size() == 0) model_push();
                    check("r_word", 32'(r), 32'(exp_q[0]));
                    if (r_ready) void'(exp_q.pop_front());
                end
                if (r_ready) acc++;
            end
            tick();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, observed hang expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int acc;
        logic [31:0] s;

        r_ready = 1'b1;
        repeat (3) tick();
        check("rst_r_valid", r_valid, 1'b0);
        check("rst_r", 32'(r), 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_seed_ready", seed_ready, 1'b1);
        rst_n = 1'b1;
        tick();
        check("idle_r_valid", r_valid, 1'b0);

        // Zero seed: lane 0 substitutes 1, busy for 17 cycles, first word at edge WU+2.
        send_seed(32'd0);
        check("load_busy", busy, 1'b1);
        check("load_seed_ready", seed_ready, 1'b0);
        for (int i = 1; i <= WU; i++) begin
            tick();
            check("warm_busy", busy, 1'b1);
            check("warm_r_valid", r_valid, 1'b0);
        end
        tick();
        check("run_busy", busy, 1'b0);
        check("run_r_valid_pre", r_valid, 1'b0);
        check("run_seed_ready", seed_ready, 1'b1);
        tick();
        check("first_r_valid", r_valid, 1'b1);
        model_push();
        check("first_word", 32'(r), 32'(exp_q[0]));

        // Sustained stream with ready held high.
        run_words(100, 0, acc);
        check("burst_count", acc, 100);

        // Back-pressure: the 1,0,0,1 pattern, then random ready.
        run_words(8, 2, acc);
        check("pattern_count", acc, 4);
        run_words(60, 1, acc);

        // Reseed in RUN with ready low: the pending word is dropped and the new stream follows the new seed.
        r_ready = 1'b0;
        check("pre_reseed_valid", r_valid, 1'b1);
        send_seed(32'hCAFEF00D);
        check("reseed_r_valid", r_valid, 1'b0);
        check("reseed_seed_ready", seed_ready, 1'b0);
        wait_valid(n);
        check("reseed_latency", n, WU + 2);
        run_words(40, 1, acc);

        // Reseed with ready high: that cycle's word still completes, then the stream restarts.
        r_ready = 1'b1;
        s = $urandom;
        send_seed(s);
        check("reseed2_r_valid", r_valid, 1'b0);
        wait_valid(n);
        check("reseed2_latency", n, WU + 2);
        run_words(30, 0, acc);

        // Reset asserted five cycles into the warm-up.
        send_seed($urandom);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_r_valid", r_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_seed_ready", seed_ready, 1'b1);
        check("midrst_r", 32'(r), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < WU + 4; i++) begin
            tick();
            check("post_rst_idle", r_valid, 1'b0);
        end
        send_seed(32'h12345678);
        wait_valid(n);
        check("post_rst_latency", n, WU + 2);
        run_words(100, 0, acc);
        check("post_rst_count", acc, 100);

`ifdef COMAR_RAND_WORD_CNT_EN
        send_seed($urandom);
        check("wcnt_clear", 32'(word_cnt), 32'd0);
        wait_valid(n);
        run_words(3, 0, acc);
        check("wcnt_three", 32'(word_cnt), 32'd3);
        run_words(70000, 3, acc);
        check("wcnt_sat", 32'(word_cnt), 32'h0000FFFF);
        send_seed($urandom);
        check("wcnt_reseed", 32'(word_cnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
